fp_operand_order: RTL and testbench
===================================

# fp_operand_order

Two-stage pipelined operand-ordering stage for the floating-point add/subtract datapath. It sits directly downstream of the magnitude comparator. It consumes that comparator's `gtXY`/`eqXY` flags together with the raw operands, and delivers to the alignment shifter:
- the major (larger) and minor (smaller) magnitudes,
- the effective operation and result sign,
- an exact-zero flag,
- a saturated exponent difference (shift amount).

A valid/ready handshake lets the shifter stall the stage.

## Interface
- `W`, 32, total operand width (sign + exponent + significand)
- `EW`, 8, exponent field width
- `SW`, 23, stored significand field width; W = 1+EW+SW
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `Data_X_i`  in  W  operand X, IEEE-754 layout
- `Data_Y_i`  in  W  operand Y
- `gtXY_i`  in  1  comparator flag: X[W-2:0] > Y[W-2:0], same cycle as data
- `eqXY_i`  in  1  comparator flag: X[W-2:0] == Y[W-2:0], same cycle as data
- `add_subt_i`  in  1  0 = X+Y, 1 = X−Y
- `valid_i`  in  1  input beat valid
- `ready_o`  out  1  stage can accept a beat this cycle
- `valid_o`  out  1  output beat valid
- `ready_i`  in  1  downstream accepts output this cycle
- `DMA_o`  out  W-1  major magnitude (exponent+significand)
- `DmP_o`  out  W-1  minor magnitude
- `swap_o`  out  1  1 = Y was the larger magnitude
- `sign_o`  out  1  sign of final result
- `real_op_o`  out  1  1 = effective subtraction
- `zero_o`  out  1  result is exactly zero
- `shift_o`  out  EW  exponent difference, saturated to SW+3

## Operation
- An input beat is accepted when `valid_i & ready_o`. Data, flags and `add_subt_i` are sampled together.
- Stage 1 (register on accept):
  - sy = Y[W-1] ^ add_subt_i
  - swap = !gtXY_i & !eqXY_i
  - DMA = swap ? Y[W-2:0] : X[W-2:0]; DmP = the other operand's magnitude
  - real_op = X[W-1] ^ sy
  - zero = eqXY_i & real_op
  - sign = zero ? 0 : (swap ? sy : X[W-1])
- Stage 2 (register when stage 2 advances):
  - diff = DMA[W-2:SW] − DmP[W-2:SW]. It is unsigned and never negative, because DMA ≥ DmP.
  - shift = (diff > SW+3) ? SW+3 : diff.
  - All other stage-1 fields pass through unchanged.
- Exponent fields are treated as raw biased values. There is no special handling for denormals, Inf or NaN (handled elsewhere).

## Timing
- Pipeline control:
  - adv2 = !v2 | ready_i
  - adv1 = !v1 | adv2
  - `ready_o` = adv1, combinational from `ready_i`
  - `valid_o` = v2
- Latency: 2 cycles from acceptance to `valid_o` when not stalled. Throughput: 1 beat/cycle.
- While `valid_o & !ready_i`, all outputs hold stable.
- Stalls:
  - A stalled stage 2 with empty stage 1 still accepts one beat into stage 1.
  - When both stages are full and `ready_i`=0, `ready_o`=0.
- Simultaneous output handoff and input accept in the same cycle advance both stages; no bubble is inserted.
- Beats are never dropped, duplicated or reordered.
- Reset (`rst`=0, asynchronous):
  - v1, v2 and all data registers clear to 0.
  - `valid_o`=0 and all data outputs = 0 immediately.
  - `ready_o`=1 during and after reset.
  - In-flight beats are discarded. Nothing is emitted until new beats are accepted after reset release.

## Test plan
- **Add, X larger:** X=0x40400000, Y=0x3F800000, add, gt=1 → 2 cycles later: DMA=0x40400000, DmP=0x3F800000, swap=0, sign=0, real_op=0, zero=0, shift=1.
- **Subtract, Y larger:** X=0x3F800000, Y=0x40400000, sub, gt=0, eq=0 → DMA=0x40400000, DmP=0x3F800000, swap=1, sign=1, real_op=1, shift=1.
- **Exact cancellation:** X=Y=0x41200000, sub, eq=1 → zero=1, sign=0, real_op=1, swap=0, shift=0. Also X=0xC1200000, Y=0x41200000, add, eq=1 → zero=1, sign=0.
- **Shift saturation:**
  - X=0x4B000000, Y=0x3F800000 → shift=23.
  - X=0x7F000000, Y=0x3F800000 → shift=26 (diff 127 saturated).
- **Backpressure:** 4 back-to-back beats with `ready_i` low for 3 cycles after first `valid_o` → `valid_o` stays 1 with outputs frozen, `ready_o` drops once both stages are full, and all 4 results appear in order exactly once.
- **Reset mid-stream:** assert `rst` low with v1=v2=1 → `valid_o`=0 and all outputs 0 without a clock edge, `ready_o`=1. After release, the first new beat emerges 2 cycles after acceptance.

Source files
------------

// File: rtl/fp_operand_order.sv
// -----------------------------------------------------------------------------
// fp_operand_order
//
// Two-stage pipelined operand-ordering stage of the floating-point add/subtract
// datapath. It sits after the magnitude comparator and feeds the alignment
// shifter. The comparator flags and the raw operands pick the major (larger)
// and minor (smaller) magnitude. The stage also derives the effective operation,
// the result sign and an exact-zero flag. The shift amount is the exponent
// difference, saturated to SW+3.
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         asynchronous active-low reset
//   Data_X_i    operand X (sign | exponent | significand)
//   Data_Y_i    operand Y
//   gtXY_i      comparator: |X| > |Y|, same cycle as the operands
//   eqXY_i      comparator: |X| == |Y|, same cycle as the operands
//   add_subt_i  0 = X+Y, 1 = X-Y
//   valid_i     input beat valid
//   ready_o     stage can accept a beat this cycle
//   valid_o     output beat valid
//   ready_i     downstream accepts the output beat this cycle
//   DMA_o       major magnitude (exponent + significand)
//   DmP_o       minor magnitude
//   swap_o      1 = Y was the larger magnitude
//   sign_o      sign of the final result
//   real_op_o   1 = effective subtraction
//   zero_o      result is exactly zero
//   shift_o     exponent difference, saturated to SW+3
// -----------------------------------------------------------------------------
module fp_operand_order #(
   parameter int W  = 32,
   parameter int EW = 8,
   parameter int SW = 23
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  Data_X_i,
   input  logic [W-1:0]  Data_Y_i,
   input  logic          gtXY_i,
   input  logic          eqXY_i,
   input  logic          add_subt_i,
   input  logic          valid_i,
   output logic          ready_o,
   output logic          valid_o,
   input  logic          ready_i,
   output logic [W-2:0]  DMA_o,
   output logic [W-2:0]  DmP_o,
   output logic          swap_o,
   output logic          sign_o,
   output logic          real_op_o,
   output logic          zero_o,
   output logic [EW-1:0] shift_o
);

   localparam logic [EW-1:0] SHIFT_MAX = EW'(SW + 3);

   // Anything beyond SW+3 shifts the minor operand entirely into the sticky
   // position, so larger distances are clamped.
   function automatic logic [EW-1:0] sat_shift(input logic [EW-1:0] exp_major,
                                                input logic [EW-1:0] exp_minor);
      logic [EW-1:0] diff;
      diff = exp_major - exp_minor;
      return (diff > SHIFT_MAX) ? SHIFT_MAX : diff;
   endfunction

   logic          vld_p1, vld_p2;
   logic          adv_p1, adv_p2;
   logic          take_p1, take_p2;

   logic [W-2:0]  dma_p1, dmp_p1;
   logic          swap_p1, sign_p1, real_op_p1, zero_p1;

   logic [W-2:0]  dma_p2, dmp_p2;
   logic          swap_p2, sign_p2, real_op_p2, zero_p2;
   logic [EW-1:0] shift_p2;

   logic          sy_c, swap_c, real_op_c, zero_c, sign_c;
   logic [W-2:0]  dma_c, dmp_c;

   // A stage may load when it is empty or its content moves on this cycle.
   assign adv_p2  = !vld_p2 | ready_i;
   assign adv_p1  = !vld_p1 | adv_p2;
   assign ready_o = adv_p1;
   assign take_p1 = valid_i & adv_p1;
   assign take_p2 = vld_p1 & adv_p2;

   always_comb begin
      sy_c      = Data_Y_i[W-1] ^ add_subt_i;
      swap_c    = !gtXY_i & !eqXY_i;
      dma_c     = swap_c ? Data_Y_i[W-2:0] : Data_X_i[W-2:0];
      dmp_c     = swap_c ? Data_X_i[W-2:0] : Data_Y_i[W-2:0];
      real_op_c = Data_X_i[W-1] ^ sy_c;
      // Equal magnitudes under effective subtraction cancel to +0.
      zero_c    = eqXY_i & real_op_c;
      sign_c    = zero_c ? 1'b0 : (swap_c ? sy_c : Data_X_i[W-1]);
   end

   // ---- stage 1 boundary: operand ordering and sign resolution ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1     <= 1'b0;
         dma_p1     <= '0;
         dmp_p1     <= '0;
         swap_p1    <= 1'b0;
         sign_p1    <= 1'b0;
         real_op_p1 <= 1'b0;
         zero_p1    <= 1'b0;
      end else begin
         if (adv_p1) vld_p1 <= valid_i;
         if (take_p1) begin
            dma_p1     <= dma_c;
            dmp_p1     <= dmp_c;
            swap_p1    <= swap_c;
            sign_p1    <= sign_c;
            real_op_p1 <= real_op_c;
            zero_p1    <= zero_c;
         end
      end
   end

   // ---- stage 2 boundary: saturated exponent difference ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p2     <= 1'b0;
         dma_p2     <= '0;
         dmp_p2     <= '0;
         swap_p2    <= 1'b0;
         sign_p2    <= 1'b0;
         real_op_p2 <= 1'b0;
         zero_p2    <= 1'b0;
         shift_p2   <= '0;
      end else begin
         if (adv_p2) vld_p2 <= vld_p1;
         if (take_p2) begin
            dma_p2     <= dma_p1;
            dmp_p2     <= dmp_p1;
            swap_p2    <= swap_p1;
            sign_p2    <= sign_p1;
            real_op_p2 <= real_op_p1;
            zero_p2    <= zero_p1;
            shift_p2   <= sat_shift(dma_p1[W-2:SW], dmp_p1[W-2:SW]);
         end
      end
   end

   assign valid_o   = vld_p2;
   assign DMA_o     = dma_p2;
   assign DmP_o     = dmp_p2;
   assign swap_o    = swap_p2;
   assign sign_o    = sign_p2;
   assign real_op_o = real_op_p2;
   assign zero_o    = zero_p2;
   assign shift_o   = shift_p2;

endmodule

// File: tb/tb_fp_operand_order.sv
module tb_fp_operand_order;
   localparam int W  = 32;
   localparam int EW = 8;
   localparam int SW = 23;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  Data_X_i, Data_Y_i;
   logic          gtXY_i, eqXY_i, add_subt_i, valid_i, ready_i;
   logic          ready_o, valid_o;
   logic [W-2:0]  DMA_o, DmP_o;
   logic          swap_o, sign_o, real_op_o, zero_o;
   logic [EW-1:0] shift_o;

   fp_operand_order #(.W(W), .EW(EW), .SW(SW)) dut (
      .clk(clk), .rst(rst),
      .Data_X_i(Data_X_i), .Data_Y_i(Data_Y_i),
      .gtXY_i(gtXY_i), .eqXY_i(eqXY_i), .add_subt_i(add_subt_i),
      .valid_i(valid_i), .ready_o(ready_o),
      .valid_o(valid_o), .ready_i(ready_i),
      .DMA_o(DMA_o), .DmP_o(DmP_o), .swap_o(swap_o), .sign_o(sign_o),
      .real_op_o(real_op_o), .zero_o(zero_o), .shift_o(shift_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-2:0]  dma;
      logic [W-2:0]  dmp;
      logic          swap;
      logic          sign;
      logic          real_op;
      logic          zero;
      logic [EW-1:0] shift;
   } res_t;

   typedef struct {
      res_t r;
      int   t;
   } ent_t;

   ent_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   emitted = 0;
   logic hold_prev = 1'b0;
   res_t prev;
   res_t obs;

   assign obs = {DMA_o, DmP_o, swap_o, sign_o, real_op_o, zero_o, shift_o};

   // Reference: ordering by magnitude as plain integers.
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic op);
      res_t r;
      int unsigned mx, my;
      logic sx, sy;
      int ed;
      mx = 32'(x[W-2:0]);
      my = 32'(y[W-2:0]);
      sx = x[W-1];
      sy = y[W-1] ^ op;
      r.swap    = (my > mx);
      r.dma     = r.swap ? y[W-2:0] : x[W-2:0];
      r.dmp     = r.swap ? x[W-2:0] : y[W-2:0];
      r.real_op = (sx != sy);
      r.zero    = (mx == my) && r.real_op;
      r.sign    = r.zero ? 1'b0 : (r.swap ? sy : sx);
      ed        = int'(r.dma[W-2:SW]) - int'(r.dmp[W-2:SW]);
      r.shift   = EW'((ed > SW + 3) ? SW + 3 : ed);
      return r;
   endfunction

   task automatic chk1(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic chkr(input string tag, input res_t got, input res_t exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic chki(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Comparator upstream is modelled here too: flags follow the operands.
   task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                        input logic v);
      Data_X_i   = x;
      Data_Y_i   = y;
      gtXY_i     = (x[W-2:0] > y[W-2:0]);
      eqXY_i     = (x[W-2:0] == y[W-2:0]);
      add_subt_i = op;
      valid_i    = v;
   endtask

   // One clock cycle: called at a falling edge with inputs applied.
   task automatic tick(output bit acc);
      logic exp_valid;
      #1;
      chk1("ready_o", ready_o, (q.size() < 2) || ready_i);
      exp_valid = 1'b0;
      if (q.size() > 0) exp_valid = ((cyc - q[0].t) >= 2);
      chk1("valid_o", valid_o, exp_valid);
      if (hold_prev) chkr("stall_hold", obs, prev);
      if (valid_o && ready_i && q.size() > 0) begin
         chkr("beat", obs, q[0].r);
         void'(q.pop_front());
         emitted++;
      end
      hold_prev = valid_o && !ready_i;
      prev      = obs;
      acc = valid_i && ready_o;
      if (acc) q.push_back('{r: model(Data_X_i, Data_Y_i, add_subt_i), t: cyc});
      @(negedge clk);
      cyc++;
   endtask

   // Single isolated beat with an explicit expected result, 2-cycle latency.
   task automatic directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic op, input res_t exp);
      bit acc;
      ready_i = 1'b1;
      drive(x, y, op, 1'b1);
      tick(acc);
      chk1({tag, "_accept"}, acc, 1'b1);
      valid_i = 1'b0;
      tick(acc);
      chk1({tag, "_valid"}, valid_o, 1'b1);
      chkr(tag, obs, exp);
      tick(acc);
   endtask

   logic [W-1:0] bx[4];
   logic [W-1:0] by[4];

   initial begin
      bit           acc;
      int           idx, stall, e0;
      bit           seen;
      logic [W-1:0] x, y;

      rst = 1'b0;
      ready_i = 1'b0;
      drive('0, '0, 1'b0, 1'b0);
      #1;
      chk1("rst_valid_o", valid_o, 1'b0);
      chk1("rst_ready_o", ready_o, 1'b1);
      chkr("rst_data", obs, '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      directed("add_x_larger", 32'h40400000, 32'h3F800000, 1'b0,
               '{31'h40400000, 31'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1});
      directed("sub_y_larger", 32'h3F800000, 32'h40400000, 1'b1,
               '{31'h40400000, 31'h3F800000, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1});
      directed("cancel_sub", 32'h41200000, 32'h41200000, 1'b1,
               '{31'h41200000, 31'h41200000, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0});
      directed("cancel_add", 32'hC1200000, 32'h41200000, 1'b0,
               '{31'h41200000, 31'h41200000, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0});
      directed("shift_23", 32'h4B000000, 32'h3F800000, 1'b0,
               '{31'h4B000000, 31'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd23});
      directed("shift_sat", 32'h7F000000, 32'h3F800000, 1'b0,
               '{31'h7F000000, 31'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd26});

      // Backpressure: 4 back-to-back beats, ready_i low 3 cycles after first valid_o.
      bx[0] = 32'h40400000; by[0] = 32'h3F800000;
      bx[1] = 32'h3F800000; by[1] = 32'hC0400000;
      bx[2] = 32'h4B000000; by[2] = 32'h3F800000;
      bx[3] = 32'hC1200000; by[3] = 32'h41200000;
      idx = 0; stall = 0; seen = 1'b0; e0 = emitted;
      for (int c = 0; c < 30 && (idx < 4 || q.size() > 0); c++) begin
         if (idx < 4) drive(bx[idx], by[idx], idx[0], 1'b1);
         else valid_i = 1'b0;
         if (seen && stall < 3) begin
            ready_i = 1'b0;
            stall++;
            #1;
            chk1("bp_ready_low", ready_o, 1'b0);
            chk1("bp_valid_high", valid_o, 1'b1);
         end else begin
            ready_i = 1'b1;
         end
         tick(acc);
         if (acc) idx++;
         if (valid_o) seen = 1'b1;
      end
      chki("bp_emitted", emitted - e0, 4);
      chki("bp_stalls", stall, 3);

      // Randomized traffic with random stalls.
      for (int c = 0; c < 400; c++) begin
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 3))
            0: y = {1'($urandom), x[W-2:0]};
            1: y[W-2:SW] = x[W-2:SW];
            default: ;
         endcase
         drive(x, y, 1'($urandom), ($urandom_range(0, 3) != 0));
         ready_i = ($urandom_range(0, 2) != 0);
         tick(acc);
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      for (int c = 0; c < 10 && q.size() > 0; c++) tick(acc);
      chki("drain", q.size(), 0);

      // Reset with both stages full.
      ready_i = 1'b0;
      for (int c = 0; c < 10 && q.size() < 2; c++) begin
         drive(32'h40400000, 32'h3F800000, 1'b0, 1'b1);
         tick(acc);
      end
      valid_i = 1'b0;
      chki("full_before_reset", q.size(), 2);
      #2;
      rst = 1'b0;
      #1;
      chk1("mid_rst_valid_o", valid_o, 1'b0);
      chk1("mid_rst_ready_o", ready_o, 1'b1);
      chkr("mid_rst_data", obs, '0);
      @(posedge clk);
      #1;
      chk1("mid_rst_hold_valid", valid_o, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      hold_prev = 1'b0;
      ready_i = 1'b1;
      drive(32'h3F800000, 32'h40400000, 1'b1, 1'b1);
      tick(acc);
      chk1("post_rst_accept", acc, 1'b1);
      valid_i = 1'b0;
      chk1("post_rst_lat1", valid_o, 1'b0);
      tick(acc);
      chk1("post_rst_lat2", valid_o, 1'b1);
      chkr("post_rst_beat", obs,
           '{31'h40400000, 31'h3F800000, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1});
      tick(acc);
      tick(acc);
      chki("post_rst_drain", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
